// File: rtl/alu_pkg.sv
// Shared ALU codes, FSM state encoding and width defaults for the ALU share arbiter.
package alu_pkg;
  localparam int XLEN_DEF = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational round-robin grant; ptr names the requester preferred on a tie.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] gnt
);
  assign gnt[0] = valid[0] & (~valid[1] | ~ptr);
  assign gnt[1] = valid[1] & (~valid[0] |  ptr);
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters via an IDLE/EXEC/RESP FSM.
// Optional perf counters compiled in with ALU_ARB_PERF_EN.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [XLEN-1:0] r0_a,
  input  logic [XLEN-1:0] r0_b,
  input  logic [2:0]      r0_ctrl,
  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [XLEN-1:0] r1_a,
  input  logic [XLEN-1:0] r1_b,
  input  logic [2:0]      r1_ctrl,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_zero,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            busy
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_grant0,
  output logic [CNT_W-1:0] perf_grant1,
  output logic [CNT_W-1:0] perf_stall
`endif
);
  logic [1:0]      state;
  logic            ptr, id_q, zero_q;
  logic [XLEN-1:0] a_q, b_q, res_q;
  logic [2:0]      ctrl_q;
  logic [1:0]      gnt;
  logic            idle, accept, rsp_done;

  rr_arb2 u_arb (
    .valid ({r1_valid, r0_valid}),
    .ptr   (ptr),
    .gnt   (gnt)
  );

  // Ready is masked during reset so nothing looks accepted on a reset edge.
  assign idle     = (state == ST_IDLE) & ~rst;
  assign r0_ready = idle & gnt[0];
  assign r1_ready = idle & gnt[1];
  assign accept   = idle & (|gnt);
  assign rsp_done = (state == ST_RESP) & rsp_ready[id_q];

  assign rsp_valid  = (state == ST_RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = ctrl_q;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      ptr    <= 1'b0;
      id_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          id_q   <= gnt[1];
          a_q    <= gnt[1] ? r1_a    : r0_a;
          b_q    <= gnt[1] ? r1_b    : r0_b;
          ctrl_q <= gnt[1] ? r1_ctrl : r0_ctrl;
          state  <= ST_EXEC;
        end
        ST_EXEC: begin
          res_q  <= alu_result;
          zero_q <= alu_zero;
          state  <= ST_RESP;
        end
        // Pointer moves only on completion so contending requesters alternate.
        ST_RESP: if (rsp_done) begin
          ptr   <= ~id_q;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall  <= '0;
    end else begin
      if (r0_ready && !(&perf_grant0)) perf_grant0 <= perf_grant0 + 1'b1;
      if (r1_ready && !(&perf_grant1)) perf_grant1 <= perf_grant1 + 1'b1;
      if ((state == ST_RESP) && !rsp_ready[id_q] && !(&perf_stall))
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed ops push expected responses,
// a negedge monitor pops and compares on each response handshake.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [2:0]  r0_ctrl, r1_ctrl;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic        rsp_zero, alu_zero, busy;
  logic [2:0]  alu_ctrl;
`ifdef ALU_ARB_PERF_EN
  logic [15:0] perf_grant0, perf_grant1, perf_stall;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_ctrl(r0_ctrl),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_ctrl(r1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
`ifdef ALU_ARB_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
  );

  // Behavioural ALU the arbiter drives.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  typedef struct { bit id; logic [31:0] res; bit z; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int g0 = 0, g1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit id, input logic [31:0] res, input bit z);
    exp_t e;
    e.id = id; e.res = res; e.z = z;
    sb.push_back(e);
  endtask

  // Monitor: any response with nothing expected is an error; pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (r0_ready) g0++;
      if (r1_ready) g1++;
      if (rsp_valid != 2'b00 && sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp actual=%b required=00", rsp_valid);
      end else if ((rsp_valid & rsp_ready) != 2'b00) begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_valid", {30'd0, rsp_valid}, e.id ? 32'd2 : 32'd1);
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.z});
      end
    end
  end

  // Called just after a posedge; returns just after the accept edge.
  task automatic issue(input bit who, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    if (!who) begin r0_valid = 1'b1; r0_a = a; r0_b = b; r0_ctrl = c; end
    else      begin r1_valid = 1'b1; r1_a = a; r1_b = b; r1_ctrl = c; end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (who ? r1_ready : r0_ready) begin
        @(posedge clk); #1;
        if (!who) r0_valid = 1'b0; else r1_valid = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL issue_timeout requester=%0d not accepted within 60 cycles", who);
    if (!who) r0_valid = 1'b0; else r1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) return;
    end
    checks++; errors++;
    $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    sb.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_r0_ready"}, {31'd0, r0_ready}, 32'd0);
    chk({tag, "_r1_ready"}, {31'd0, r1_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_ctrl"}, {29'd0, alu_ctrl}, 32'd0);
    chk({tag, "_rsp_result"}, rsp_result, 32'd0);
    chk({tag, "_rsp_zero"}, {31'd0, rsp_zero}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; r0_valid = 1'b1; r1_valid = 1'b0;
    r0_a = 0; r0_b = 0; r0_ctrl = 0; r1_a = 0; r1_b = 0; r1_ctrl = 0;
    rsp_ready = 2'b01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1; r0_valid = 1'b0; rst = 1'b0;

    // Single op: 5 - 3 = 2
    push(0, 32'd2, 0);
    issue(0, 32'd5, 32'd3, ALU_SUB);
    @(negedge clk);
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_r0_ready", {31'd0, r0_ready}, 32'd0);
    chk("exec_alu_a", alu_a, 32'd5);
    chk("exec_alu_b", alu_b, 32'd3);
    chk("exec_alu_ctrl", {29'd0, alu_ctrl}, {29'd0, ALU_SUB});
    @(negedge clk);
    chk("lat_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    drain();

    // Contention after reset: grant order r0, r1, r0, r1
    do_reset();
    g0 = 0; g1 = 0;
    rsp_ready = 2'b11;
    push(0, 32'd2, 0); push(1, 32'd0, 1); push(0, 32'd2, 0); push(1, 32'd0, 1);
    r0_a = 32'd1; r0_b = 32'd1; r0_ctrl = ALU_ADD;
    r1_a = 32'hF0; r1_b = 32'h0F; r1_ctrl = ALU_AND;
    r0_valid = 1'b1; r1_valid = 1'b1;
    drain();
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk("cont_g0", g0, 32'd2);
    chk("cont_g1", g1, 32'd2);

    // Backpressure: r1 SLT -1 < 1 held for 10 cycles while r0 waits
    rsp_ready = 2'b00;
    push(1, 32'd1, 0);
    issue(1, 32'hFFFF_FFFF, 32'd1, ALU_SLT);
    r0_valid = 1'b1; r0_a = 32'd7; r0_b = 32'd0; r0_ctrl = ALU_ADD;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {30'd0, rsp_valid}, 32'd2);
      chk("bp_result", rsp_result, 32'd1);
      chk("bp_r0_ready", {31'd0, r0_ready}, 32'd0);
    end
    @(posedge clk); #1;
    push(0, 32'd7, 0);
    rsp_ready = 2'b10;
    issue(0, 32'd7, 32'd0, ALU_ADD);
    rsp_ready = 2'b01;
    drain();

    // Wrong-owner ready: r0 owns, only r1 ready offered
    rsp_ready = 2'b10;
    push(0, 32'd0, 1);
    issue(0, 32'd4, 32'd4, ALU_SUB);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wo_busy", {31'd0, busy}, 32'd1);
      chk("wo_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    end
    @(posedge clk); #1; rsp_ready = 2'b01;
    drain();

    // Reset during EXEC: op vanishes, pointer back to r0
    rsp_ready = 2'b11;
    issue(1, 32'd3, 32'd4, ALU_ADD);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midrst");
    @(posedge clk); #1; rst = 1'b0;
    r0_a = 32'd9; r1_a = 32'd9; r0_valid = 1'b1; r1_valid = 1'b1;
    @(negedge clk);
    chk("tie_r0_ready", {31'd0, r0_ready}, 32'd1);
    chk("tie_r1_ready", {31'd0, r1_ready}, 32'd0);
    #1; r0_valid = 1'b0; r1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {29'd0, busy, rsp_valid}, 32'd0);
    end

`ifdef ALU_ARB_PERF_EN
    do_reset();
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      push(0, 32'd10 + i, 0);
      issue(0, 32'd10, i, ALU_ADD);
      drain();
    end
    push(1, 32'd6, 0);
    issue(1, 32'd6, 32'd0, ALU_OR);
    drain();
    rsp_ready = 2'b00;
    push(1, 32'd3, 0);
    issue(1, 32'd1, 32'd2, ALU_OR);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1; rsp_ready = 2'b11;
    drain();
    chk("perf_grant0", {16'd0, perf_grant0}, 32'd3);
    chk("perf_grant1", {16'd0, perf_grant1}, 32'd2);
    chk("perf_stall", {16'd0, perf_stall}, 32'd4);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single ALU datapath, selected by the 3-bit ALUControl code, between two requesters: requester 0 is the main execute path and requester 1 is the auxiliary/multi-cycle unit.
- Round-robin arbitration with a valid/ready handshake on both the request and response sides.
- Operands, control and owner ID are registered. The external combinational ALU is driven for one cycle and its result is captured and returned to the owning requester.
- Sits between the control unit / execute sequencing and the ALU instance.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 16, width of the perf counters (used only when the optional feature is compiled in).

Ports:
- clk  in  1  clock, all state on the rising edge
- rst  in  1  synchronous, active-high reset
- r0_valid  in  1  requester 0 has an op
- r0_ready  out  1  requester 0 op accepted this cycle
- r0_a, r0_b  in  XLEN  requester 0 operands
- r0_ctrl  in  3  requester 0 ALUControl code
- r1_valid, r1_ready, r1_a, r1_b, r1_ctrl  same as the r0 set, for requester 1
- rsp_valid  out  2  one-hot; bit i means the response belongs to requester i
- rsp_ready  in  2  per-requester response acceptance
- rsp_result  out  XLEN  captured ALU result
- rsp_zero  out  1  captured ALU zero flag
- alu_a, alu_b  out  XLEN  ALU operand drive
- alu_ctrl  out  3  ALU control drive
- alu_result  in  XLEN  ALU combinational result
- alu_zero  in  1  ALU zero flag
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (sync, rst=1 at the edge):
  - state=IDLE, priority pointer=0.
  - Operand/ctrl/id/result registers cleared.
  - All outputs 0: r*_ready, rsp_valid, alu_a, alu_b, alu_ctrl, rsp_result, rsp_zero, busy.
  - Reset mid-operation discards the in-flight op; no response is ever produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from r*_valid and the pointer. Exactly one r*_ready is asserted, only in IDLE and only to the winner.
  - Both valid: the requester equal to the pointer wins. One valid: that requester wins regardless of the pointer.
  - On a grant: latch a, b, ctrl and id, then go to EXEC.
  - No valid: stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_ctrl are driven from the latched registers. They are held at the latched values in every state and are only 0 after reset.
  - At the end of the cycle, capture alu_result/alu_zero into the response registers, then go to RESP.
- RESP:
  - rsp_valid[id]=1, other bit 0.
  - rsp_result and rsp_zero are stable until the handshake completes.
  - rsp_ready of the non-owner is ignored.
  - On rsp_ready[id]=1: pointer = ~id, go to IDLE.
  - Otherwise hold indefinitely (backpressure).
- Timing:
  - Latency is 3 edges from the accept edge to the earliest response-complete edge.
  - Throughput is at most 1 op per 3 cycles. No new request is accepted in EXEC or RESP.
- Pointer updates only on response completion, so the two requesters strictly alternate under contention.
- ctrl is passed through unchecked. Undefined codes (100, 110, 111) are the ALU's responsibility.
- r*_valid may drop without a handshake. The arbiter samples only on the accept edge, and inputs are don't-care in other states.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- When defined:
  - Adds outputs perf_grant0 and perf_grant1, each CNT_W wide, counting accepted ops per requester.
  - Adds output perf_stall, CNT_W wide, counting cycles in RESP with rsp_ready[id]=0.
  - All counters saturate at all-ones and reset to 0.
- When undefined: these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - ALUControl localparams: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - State encoding ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2.
  - XLEN default.
- One natural sub-module, rr_arb2: 2-way combinational round-robin grant from valid bits and the pointer. The FSM and datapath registers stay in the top.

Test Plan:
- Single op: reset, then r0 with a=5, b=3, ctrl=001, rsp_ready=2'b01 always.
  - Expect r0_ready for 1 cycle, then busy.
  - Expect rsp_valid=2'b01 with result=2, zero=0 on the 3rd cycle after accept.
- Contention: r0 and r1 valid continuously after reset, r0 ADD 1+1, r1 AND F0&0F.
  - Expect grant order r0, r1, r0, r1.
  - Expect responses 2 (zero=0), then 0 (zero=1).
- Backpressure: r1 SLT a=-1, b=1, rsp_ready=0 for 10 cycles.
  - Expect rsp_valid=2'b10 and result=1 held stable.
  - Expect r0_ready=0 throughout; completes on the first rsp_ready[1].
- Wrong-owner ready: owner r0, rsp_ready=2'b10.
  - Expect state to stay RESP; completes only on rsp_ready=2'b01.
- Reset mid-op: assert rst in EXEC.
  - Expect all outputs 0 next cycle, no response, and r0 winning the next tie (pointer=0).
- With ALU_ARB_PERF_EN: 3 r0 ops, 2 r1 ops, 4 stall cycles.
  - Expect perf_grant0=3, perf_grant1=2, perf_stall=4.
